// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: steps shift_unit once per bit (start/operand/dir/amount in; busy/done/err/result and su_* drive out; su_shift_out/su_shift_flag back)
module shift_seq_ctrl #(
  parameter int width = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] operand,
  input  logic             dir,
  input  logic [CNT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [width-1:0] result,
  output logic [width-1:0] su_A,
  output logic [width-1:0] su_B,
  output logic [1:0]       su_ALU_FUN,
  output logic             su_shift_enable,
  input  logic [width-1:0] su_shift_out,
  input  logic             su_shift_flag
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q;
  logic [width-1:0] work_q, res_q;
  logic [CNT_W-1:0] cnt_q, amt_sat;
  logic dir_q, err_q;
  assign amt_sat = amount > CNT_W'(width) ? CNT_W'(width) : amount;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          work_q  <= operand;
          dir_q   <= dir;
          cnt_q   <= amt_sat;
          err_q   <= 1'b0;
          res_q   <= amt_sat == '0 ? operand : res_q;
          state_q <= amt_sat == '0 ? DONE : ISSUE;
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          work_q  <= su_shift_out;
          cnt_q   <= cnt_q - 1'b1;
          err_q   <= ~su_shift_flag;
          res_q   <= (!su_shift_flag || cnt_q == CNT_W'(1)) ? su_shift_out : res_q;
          state_q <= (!su_shift_flag || cnt_q == CNT_W'(1)) ? DONE : ISSUE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy            = state_q != IDLE;
  assign done            = state_q == DONE;
  assign su_shift_enable = state_q == ISSUE;
  assign su_A            = work_q;
  assign su_B            = '0;
  assign su_ALU_FUN      = {1'b0, dir_q};
  assign result          = res_q;
  assign err             = err_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: randomized self-checking bench with a behavioural shift model and a shift_unit stand-in
module tb_shift_seq_ctrl;
  logic clk = 0, reset = 1, start = 0, dir = 0;
  logic [15:0] operand = '0;
  logic [4:0] amount = '0;
  logic busy, done, err, su_shift_enable;
  logic [15:0] result, su_A, su_B;
  logic [1:0] su_ALU_FUN;
  logic [15:0] su_out = '0;
  logic su_flag = 0;
  int kill_k = 0, iss = 0;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  bit m_act = 0, m_dir = 0, m_err = 0;
  int m_p = 0, m_end = 0;
  logic [15:0] m_op = '0, m_res = '0;

  shift_seq_ctrl #(.width(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .operand(operand), .dir(dir), .amount(amount),
    .busy(busy), .done(done), .err(err), .result(result), .su_A(su_A), .su_B(su_B),
    .su_ALU_FUN(su_ALU_FUN), .su_shift_enable(su_shift_enable),
    .su_shift_out(su_out), .su_shift_flag(su_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] shf(input logic [15:0] v, input logic d, input int s);
    return d ? v << s : v >> s;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // shift_unit stand-in: one registered shift per enable; flag dropped on the kill_k-th issue
  always @(posedge clk) begin
    if (!busy) iss <= 0;
    else if (su_shift_enable) iss <= iss + 1;
    if (su_shift_enable) su_out <= su_ALU_FUN[0] ? su_A << 1 : su_A >> 1;
    su_flag <= su_shift_enable && !(kill_k != 0 && iss + 1 == kill_k);
  end

  // operation-level model: phase p counts cycles since acceptance, done at 2*steps+1
  always @(posedge clk) begin
    int n, steps;
    if (reset) begin
      m_act = 0; m_res = '0; m_err = 0;
    end else if (!m_act) begin
      if (start) begin
        n = amount > 16 ? 16 : int'(amount);
        steps = kill_k != 0 ? kill_k : n;
        m_act = 1; m_p = 1; m_end = 2 * steps + 1;
        m_op = operand; m_dir = dir; m_err = 0;
        if (m_p == m_end) m_res = shf(m_op, m_dir, steps);
      end
    end else if (m_p == m_end) begin
      m_act = 0;
    end else begin
      m_p++;
      if (m_p == m_end) begin
        m_res = shf(m_op, m_dir, (m_end - 1) / 2);
        m_err = kill_k != 0;
      end
    end
  end

  always @(negedge clk) begin
    bit e_en;
    if (chk_en) begin
      e_en = m_act && (m_p % 2 == 1) && m_p < m_end;
      chk("busy", busy, m_act);
      chk("done", done, m_act && m_p == m_end);
      chk("enable", su_shift_enable, e_en);
      chk("result", result, m_res);
      chk("err", err, m_err);
      chk("su_B", su_B, 0);
      if (e_en) begin
        chk("su_A", su_A, shf(m_op, m_dir, (m_p - 1) / 2));
        chk("su_ALU_FUN", su_ALU_FUN, {1'b0, m_dir});
      end
    end
  end

  task automatic run(input logic [15:0] op, input logic d, input logic [4:0] amt, input int kill,
                     input bit noise, output int lat);
    @(negedge clk);
    kill_k = kill; operand = op; dir = d; amount = amt; start = 1;
    @(negedge clk);
    start = 0; operand = 16'($urandom); dir = 1'($urandom); amount = 5'($urandom);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      start = noise && (lat == 2 || lat == 5);
      if (start) operand = 16'($urandom);
    end
    start = 0;
    chk("timeout", lat < 100, 1);
  endtask

  initial begin
    int lat, n, kill;
    logic [4:0] amt;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_enable", su_shift_enable, 0);
    reset = 0;
    run(16'h1234, 0, 0, 0, 0, lat);
    chk("s1_lat", lat, 1); chk("s1_res", result, 16'h1234); chk("s1_err", err, 0);
    run(16'hB3C5, 0, 3, 0, 1, lat);
    chk("s2_lat", lat, 7); chk("s2_res", result, 16'h1678); chk("s2_model", m_res, 16'h1678);
    run(16'h00FF, 1, 4, 0, 0, lat);
    chk("s3_lat", lat, 9); chk("s3_res", result, 16'h0FF0);
    run(16'hFFFF, 1, 20, 0, 0, lat);
    chk("s3_sat_lat", lat, 33); chk("s3_sat_res", result, 16'h0000);
    run(16'hA5A5, 0, 5, 1, 0, lat);
    chk("s5_lat", lat, 3); chk("s5_err", err, 1); chk("s5_res", result, 16'h52D2);
    run(16'h0001, 1, 2, 0, 0, lat);
    chk("s5_err_clr", err, 0); chk("s5b_res", result, 16'h0004);
    @(negedge clk);
    kill_k = 0; operand = 16'h0F0F; dir = 1; amount = 6; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("s6_busy", busy, 0); chk("s6_done", done, 0);
    chk("s6_res", result, 0); chk("s6_en", su_shift_enable, 0);
    repeat (15) @(negedge clk);
    run(16'h8001, 0, 15, 0, 0, lat);
    chk("s6_lat", lat, 31); chk("s6_after", result, 16'h0001);
    for (int i = 0; i < 40; i++) begin
      amt = 5'($urandom_range(0, 31));
      n = amt > 16 ? 16 : int'(amt);
      kill = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
      run(16'($urandom), 1'($urandom), amt, kill, 1'($urandom), lat);
      chk("rand_lat", lat, 2 * (kill != 0 ? kill : n) + 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Multi-bit shift sequencer for the single-bit shift_unit datapath.
- Accepts a shift request: operand, direction, amount.
- Drives shift_unit once per bit position, recirculating its registered result until the shift count is exhausted.
- Sits between the ALU control decode and the shift_unit instance, and owns that instance's A/B/ALU_FUN/shift_enable inputs.

Parameters:
width, 16, datapath width; must match the attached shift_unit.
CNT_W, 5, amount/counter width; must satisfy 2**CNT_W > width.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request strobe; sampled only in IDLE.
operand  input  width  value to shift; latched on accepted start.
dir  input  1  0 = logical right, 1 = logical left; latched on accepted start.
amount  input  CNT_W  number of bit positions; latched on accepted start.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle completion pulse.
err  output  1  sticky per operation; set when shift_unit fails to flag a shift.
result  output  width  final shifted value; held until the next accepted start.
su_A  output  width  to shift_unit A.
su_B  output  width  to shift_unit B; constant 0.
su_ALU_FUN  output  2  to shift_unit ALU_FUN: 2'b00 for right, 2'b01 for left.
su_shift_enable  output  1  to shift_unit shift_enable.
su_shift_out  input  width  from shift_unit; registered, 1-cycle latency.
su_shift_flag  input  1  from shift_unit; 1 when the previous cycle issued a shift.

Behaviour:
- Reset (synchronous, overrides everything):
  - State goes to IDLE.
  - busy, done, err, result, su_A, su_ALU_FUN, su_shift_enable all = 0.
  - Reset mid-operation abandons the operation silently; no done pulse.
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered or decoded from state and registers only, with no combinational path from inputs.
- IDLE:
  - On start=1: latch operand into work register, dir, and cnt = min(amount, width). Amounts above width saturate to width, giving result 0 after width steps.
  - Clear err on accept.
  - If cnt==0: go to DONE, with result = operand.
  - Otherwise go to ISSUE.
- ISSUE:
  - su_shift_enable=1, su_A=work, su_ALU_FUN = dir ? 2'b01 : 2'b00.
  - Next state is always WAIT.
- WAIT:
  - su_shift_enable=0. su_shift_out is valid this cycle.
  - Load work <= su_shift_out; cnt <= cnt-1.
  - If su_shift_flag==0: set err=1, result <= su_shift_out, go to DONE (abort).
  - Else if cnt==1: result <= su_shift_out, go to DONE.
  - Else go to ISSUE.
- DONE:
  - done=1 for exactly this cycle; next state is IDLE.
- Start handling: start is ignored in ISSUE, WAIT and DONE; there is no queuing. A start asserted in the IDLE cycle immediately after DONE is accepted.
- Latency: with start sampled in cycle 0 and effective amount n, done is high in cycle 2n+1. busy is high in cycles 1 through 2n+1.
- su_A holds work, and su_ALU_FUN holds its last value, outside ISSUE. Only su_shift_enable qualifies them.
- result is unchanged by reset-free idle cycles and by ignored starts.
- dir, operand and amount may change freely after acceptance without effect.

Test Plan:
1. Reset, then start with operand=16'h1234, amount=0, dir=0 -> done in cycle 1, result=16'h1234, err=0, su_shift_enable never high.
2. operand=16'hB3C5, dir=0, amount=3 -> exactly 3 su_shift_enable pulses, each su_ALU_FUN=00; done in cycle 7; result=16'h1678; busy high in cycles 1-7.
3. operand=16'h00FF, dir=1, amount=4 -> su_ALU_FUN=01; done in cycle 9; result=16'h0FF0. Then amount=20 on operand=16'hFFFF -> saturates to 16 steps, done in cycle 33, result=16'h0000.
4. During scenario 2, pulse start again in cycles 2 and 5 with different operands -> ignored; result still 16'h1678. A start in the cycle after done is accepted.
5. Force su_shift_flag=0 in the first WAIT of a 5-bit shift -> err=1, done in cycle 3, no further enable pulses. err clears on the next accepted start.
6. Assert reset in cycle 4 of a 6-bit shift -> next cycle busy=0, done=0, result=0, su_shift_enable=0; no done pulse follows. A new start then completes normally.
